// File: rtl/rvfi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_seq_pkg
// Brief   : RVFI record type, widths and channel-slice packing for the
//           in-order retirement sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package rvfi_seq_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int ORDER_W = 64;
    localparam int MASK_W  = XLEN / 8;

    typedef struct packed {
        logic [ORDER_W-1:0] order;
        logic [ILEN-1:0]    insn;
        logic               trap;
        logic               halt;
        logic               intr;
        logic [1:0]         mode;
        logic [1:0]         ixl;
        logic [4:0]         rs1_addr;
        logic [4:0]         rs2_addr;
        logic [XLEN-1:0]    rs1_rdata;
        logic [XLEN-1:0]    rs2_rdata;
        logic [4:0]         rd_addr;
        logic [XLEN-1:0]    rd_wdata;
        logic [XLEN-1:0]    pc_rdata;
        logic [XLEN-1:0]    pc_wdata;
        logic [XLEN-1:0]    mem_addr;
        logic [MASK_W-1:0]  mem_rmask;
        logic [MASK_W-1:0]  mem_wmask;
        logic [XLEN-1:0]    mem_rdata;
        logic [XLEN-1:0]    mem_wdata;
    } rvfi_rec_t;

    localparam int REC_W = $bits(rvfi_rec_t);

    // Builds one record from a single channel's slice of the RVFI bus.
    function automatic rvfi_rec_t pack_rvfi(
        input logic [ORDER_W-1:0] order,     input logic [ILEN-1:0]   insn,
        input logic               trap,      input logic              halt,
        input logic               intr,      input logic [1:0]        mode,
        input logic [1:0]         ixl,       input logic [4:0]        rs1_addr,
        input logic [4:0]         rs2_addr,  input logic [XLEN-1:0]   rs1_rdata,
        input logic [XLEN-1:0]    rs2_rdata, input logic [4:0]        rd_addr,
        input logic [XLEN-1:0]    rd_wdata,  input logic [XLEN-1:0]   pc_rdata,
        input logic [XLEN-1:0]    pc_wdata,  input logic [XLEN-1:0]   mem_addr,
        input logic [MASK_W-1:0]  mem_rmask, input logic [MASK_W-1:0] mem_wmask,
        input logic [XLEN-1:0]    mem_rdata, input logic [XLEN-1:0]   mem_wdata);
        rvfi_rec_t r;
        r = '{order, insn, trap, halt, intr, mode, ixl, rs1_addr, rs2_addr,
              rs1_rdata, rs2_rdata, rd_addr, rd_wdata, pc_rdata, pc_wdata,
              mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata};
        return r;
    endfunction

    // Flattens a record for storage and recovers it on read-back.
    function automatic logic [REC_W-1:0] unpack_rvfi_flat(input rvfi_rec_t r);
        return r;
    endfunction

    function automatic rvfi_rec_t pack_rvfi_flat(input logic [REC_W-1:0] v);
        return rvfi_rec_t'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_seq_slot_ram.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_seq_slot_ram
// Brief   : DEPTH x record reorder storage, NRET write ports, one
//           combinational read port and a per-slot valid vector.
// Rev     : 1.0  initial release
// ============================================================================
module rvfi_seq_slot_ram
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int W     = REC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRET-1:0]       i_we,
    input  logic [NRET*IDX_W-1:0] i_waddr,
    input  logic [NRET*W-1:0]     i_wdata,
    input  logic                  i_clr,
    input  logic [IDX_W-1:0]      i_clr_addr,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [W-1:0]          o_rdata,
    output logic [DEPTH-1:0]      o_valid
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int c = 0; c < NRET; c++) begin
            if (i_we[c]) w_set[i_waddr[c*IDX_W +: IDX_W]] = 1'b1;
        end
        w_clr[i_clr_addr] = i_clr;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NRET; c++) begin
            if (i_we[c]) r_mem[i_waddr[c*IDX_W +: IDX_W]] <= i_wdata[c*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_valid <= '0;
        else     r_valid <= (r_valid | w_set) & ~w_clr;
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_valid = r_valid;
endmodule
`default_nettype wire

// File: rtl/rvfi_order_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rvfi_order_sequencer
// Brief   : Reorders up to NRET out-of-order RVFI retirements per cycle into a
//           single in-order channel with a check strobe and sticky error.
// Rev     : 1.0  initial release
// ============================================================================
module rvfi_order_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int                 NRET        = 1,
    parameter int                 DEPTH       = 8,
    parameter logic [ORDER_W-1:0] CHECK_ORDER = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NRET-1:0]           rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]   rvfi_order,
    input  logic [NRET*ILEN-1:0]      rvfi_insn,
    input  logic [NRET-1:0]           rvfi_trap,
    input  logic [NRET-1:0]           rvfi_halt,
    input  logic [NRET-1:0]           rvfi_intr,
    input  logic [NRET*2-1:0]         rvfi_mode,
    input  logic [NRET*2-1:0]         rvfi_ixl,
    input  logic [NRET*5-1:0]         rvfi_rs1_addr,
    input  logic [NRET*5-1:0]         rvfi_rs2_addr,
    input  logic [NRET*XLEN-1:0]      rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0]      rvfi_rs2_rdata,
    input  logic [NRET*5-1:0]         rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0]      rvfi_rd_wdata,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]      rvfi_pc_wdata,
    input  logic [NRET*XLEN-1:0]      rvfi_mem_addr,
    input  logic [NRET*MASK_W-1:0]    rvfi_mem_rmask,
    input  logic [NRET*MASK_W-1:0]    rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]      rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]      rvfi_mem_wdata,
    output logic                      out_valid,
    output logic [ORDER_W-1:0]        out_order,
    output logic [ILEN-1:0]           out_insn,
    output logic                      out_trap,
    output logic                      out_halt,
    output logic                      out_intr,
    output logic [1:0]                out_mode,
    output logic [1:0]                out_ixl,
    output logic [4:0]                out_rs1_addr,
    output logic [4:0]                out_rs2_addr,
    output logic [XLEN-1:0]           out_rs1_rdata,
    output logic [XLEN-1:0]           out_rs2_rdata,
    output logic [4:0]                out_rd_addr,
    output logic [XLEN-1:0]           out_rd_wdata,
    output logic [XLEN-1:0]           out_pc_rdata,
    output logic [XLEN-1:0]           out_pc_wdata,
    output logic [XLEN-1:0]           out_mem_addr,
    output logic [MASK_W-1:0]         out_mem_rmask,
    output logic [MASK_W-1:0]         out_mem_wmask,
    output logic [XLEN-1:0]           out_mem_rdata,
    output logic [XLEN-1:0]           out_mem_wdata,
    output logic                      check,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [ORDER_W-1:0]    r_next_order;
    logic                  r_out_valid;
    logic                  r_check;
    rvfi_rec_t             r_out_rec;
    logic [CNT_W-1:0]      r_pending;
    logic                  r_err;

    logic [IDX_W-1:0]      w_idx [NRET];
    logic [NRET-1:0]       w_in_win;
    logic [NRET-1:0]       w_we;
    logic [NRET*IDX_W-1:0] w_waddr;
    logic [NRET*REC_W-1:0] w_wdata;
    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_set;
    logic [DEPTH-1:0]      w_clr;
    logic [DEPTH-1:0]      w_valid_next;
    logic [REC_W-1:0]      w_rdata;
    rvfi_rec_t             w_rd_rec;
    logic [IDX_W-1:0]      w_head;
    logic                  w_emit;
    logic                  w_ok;
    logic                  w_bad;
    logic [CNT_W-1:0]      w_cnt;

    for (genvar c = 0; c < NRET; c++) begin : g_chan
        logic [ORDER_W-1:0] w_ord;
        assign w_ord       = rvfi_order[c*ORDER_W +: ORDER_W];
        assign w_idx[c]    = w_ord[IDX_W-1:0];
        // Subtracting only after the lower-bound test keeps the window check wrap-free.
        assign w_in_win[c] = (w_ord >= r_next_order) &&
                             ((w_ord - r_next_order) < ORDER_W'(DEPTH));
        assign w_waddr[c*IDX_W +: IDX_W] = w_ord[IDX_W-1:0];
        assign w_wdata[c*REC_W +: REC_W] = unpack_rvfi_flat(pack_rvfi(
            w_ord, rvfi_insn[c*ILEN +: ILEN], rvfi_trap[c], rvfi_halt[c],
            rvfi_intr[c], rvfi_mode[c*2 +: 2], rvfi_ixl[c*2 +: 2],
            rvfi_rs1_addr[c*5 +: 5], rvfi_rs2_addr[c*5 +: 5],
            rvfi_rs1_rdata[c*XLEN +: XLEN], rvfi_rs2_rdata[c*XLEN +: XLEN],
            rvfi_rd_addr[c*5 +: 5], rvfi_rd_wdata[c*XLEN +: XLEN],
            rvfi_pc_rdata[c*XLEN +: XLEN], rvfi_pc_wdata[c*XLEN +: XLEN],
            rvfi_mem_addr[c*XLEN +: XLEN], rvfi_mem_rmask[c*MASK_W +: MASK_W],
            rvfi_mem_wmask[c*MASK_W +: MASK_W], rvfi_mem_rdata[c*XLEN +: XLEN],
            rvfi_mem_wdata[c*XLEN +: XLEN]));
    end

    // Lower-indexed channels win slot collisions, even when they are themselves illegal.
    always_comb begin
        w_we  = '0;
        w_set = '0;
        w_bad = 1'b0;
        w_ok  = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            w_ok = w_in_win[c] && !w_valid[w_idx[c]];
            for (int k = 0; k < c; k++) begin
                if (rvfi_valid[k] && (w_idx[k] == w_idx[c])) w_ok = 1'b0;
            end
            if (rvfi_valid[c]) begin
                if (w_ok) begin
                    w_we[c]         = 1'b1;
                    w_set[w_idx[c]] = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
        end
    end

    assign w_head   = r_next_order[IDX_W-1:0];
    assign w_emit   = w_valid[w_head];
    assign w_rd_rec = pack_rvfi_flat(w_rdata);

    always_comb begin
        w_clr         = '0;
        w_clr[w_head] = w_emit;
        w_valid_next  = (w_valid | w_set) & ~w_clr;
        w_cnt         = '0;
        for (int i = 0; i < DEPTH; i++) w_cnt = w_cnt + CNT_W'(w_valid_next[i]);
    end

    rvfi_seq_slot_ram #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .W     (REC_W)
    ) u_slot_ram (
        .clk        (clock),
        .rst        (reset),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_clr      (w_emit),
        .i_clr_addr (w_head),
        .i_raddr    (w_head),
        .o_rdata    (w_rdata),
        .o_valid    (w_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_order <= '0;
            r_out_valid  <= 1'b0;
            r_check      <= 1'b0;
            r_out_rec    <= '0;
            r_pending    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_check     <= w_emit && (w_rd_rec.order == CHECK_ORDER);
            r_pending   <= w_cnt;
            r_err       <= r_err | w_bad;
            if (w_emit) begin
                r_out_rec    <= w_rd_rec;
                r_next_order <= r_next_order + ORDER_W'(1);
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_order     = r_out_rec.order;
    assign out_insn      = r_out_rec.insn;
    assign out_trap      = r_out_rec.trap;
    assign out_halt      = r_out_rec.halt;
    assign out_intr      = r_out_rec.intr;
    assign out_mode      = r_out_rec.mode;
    assign out_ixl       = r_out_rec.ixl;
    assign out_rs1_addr  = r_out_rec.rs1_addr;
    assign out_rs2_addr  = r_out_rec.rs2_addr;
    assign out_rs1_rdata = r_out_rec.rs1_rdata;
    assign out_rs2_rdata = r_out_rec.rs2_rdata;
    assign out_rd_addr   = r_out_rec.rd_addr;
    assign out_rd_wdata  = r_out_rec.rd_wdata;
    assign out_pc_rdata  = r_out_rec.pc_rdata;
    assign out_pc_wdata  = r_out_rec.pc_wdata;
    assign out_mem_addr  = r_out_rec.mem_addr;
    assign out_mem_rmask = r_out_rec.mem_rmask;
    assign out_mem_wmask = r_out_rec.mem_wmask;
    assign out_mem_rdata = r_out_rec.mem_rdata;
    assign out_mem_wdata = r_out_rec.mem_wdata;
    assign check         = r_check;
    assign pending       = r_pending;
    assign err           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_rvfi_order_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvfi_order_sequencer
// Brief   : Directed self-checking bench for rvfi_order_sequencer (NRET=2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_rvfi_order_sequencer;
    import rvfi_seq_pkg::*;

    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NRET-1:0]        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [NRET*ORDER_W-1:0] rvfi_order;
    logic [NRET*ILEN-1:0]   rvfi_insn;
    logic [NRET*2-1:0]      rvfi_mode, rvfi_ixl;
    logic [NRET*5-1:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [NRET*XLEN-1:0]   rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [NRET*XLEN-1:0]   rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [NRET*XLEN-1:0]   rvfi_mem_rdata, rvfi_mem_wdata;
    logic [NRET*MASK_W-1:0] rvfi_mem_rmask, rvfi_mem_wmask;

    logic                   out_valid, out_trap, out_halt, out_intr, check, err;
    logic [ORDER_W-1:0]     out_order;
    logic [ILEN-1:0]        out_insn;
    logic [1:0]             out_mode, out_ixl;
    logic [4:0]             out_rs1_addr, out_rs2_addr, out_rd_addr;
    logic [XLEN-1:0]        out_rs1_rdata, out_rs2_rdata, out_rd_wdata;
    logic [XLEN-1:0]        out_pc_rdata, out_pc_wdata, out_mem_addr;
    logic [XLEN-1:0]        out_mem_rdata, out_mem_wdata;
    logic [MASK_W-1:0]      out_mem_rmask, out_mem_wmask;
    logic [3:0]             pending;

    int n_tests = 0;
    int n_fails = 0;

    rvfi_order_sequencer #(.NRET(NRET), .DEPTH(DEPTH), .CHECK_ORDER(64'd0)) dut (
        .clock(clock), .reset(reset),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata),
        .out_valid(out_valid), .out_order(out_order), .out_insn(out_insn),
        .out_trap(out_trap), .out_halt(out_halt), .out_intr(out_intr),
        .out_mode(out_mode), .out_ixl(out_ixl),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rs1_rdata(out_rs1_rdata), .out_rs2_rdata(out_rs2_rdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask), .out_mem_rdata(out_mem_rdata),
        .out_mem_wdata(out_mem_wdata),
        .check(check), .pending(pending), .err(err)
    );

    function automatic logic [ILEN-1:0] exp_insn(input logic [63:0] ord, input logic [7:0] tag);
        return ILEN'(ord) + ILEN'(32'h13) + (ILEN'(tag) << 16);
    endfunction

    task automatic clear_inputs();
        {rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr} = '0;
        {rvfi_order, rvfi_insn, rvfi_mode, rvfi_ixl} = '0;
        {rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr} = '0;
        {rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata} = '0;
        {rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr} = '0;
        {rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask} = '0;
    endtask

    task automatic set_ch(input int c, input logic [63:0] ord, input logic [7:0] tag);
        rvfi_valid[c] = 1'b1;
        rvfi_order[c*ORDER_W +: ORDER_W] = ord;
        rvfi_insn[c*ILEN +: ILEN] = exp_insn(ord, tag);
        rvfi_pc_rdata[c*XLEN +: XLEN] = XLEN'(ord << 2);
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later and inputs cleared.
    task automatic tick();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        set_ch(0, 64'd0, 8'd0);
        set_ch(1, 64'd1, 8'd0);
        tick();
        reset = 1'b0;
        n_tests++;
        if ({out_valid, check, err} !== 3'b000 || pending !== 4'd0) begin
            n_fails++;
            $display("FAIL reset_ctl: valid=%0b check=%0b err=%0b pending=%0d (want 0 0 0 0)",
                     out_valid, check, err, pending);
        end
        n_tests++;
        if (out_order !== 64'd0 || out_insn !== '0 || out_pc_rdata !== '0) begin
            n_fails++;
            $display("FAIL reset_payload: order=%0d insn=%h pc=%h (want 0 0 0)",
                     out_order, out_insn, out_pc_rdata);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd0) begin
            n_fails++;
            $display("FAIL reset_ignores_inputs: valid=%0b pending=%0d (want 0 0)", out_valid, pending);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        set_ch(0, 64'd0, 8'd0); tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("FAIL in_order_c2: valid=%0b (want 0)", out_valid);
        end
        set_ch(0, 64'd1, 8'd0); tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd0 || check !== 1'b1 || out_insn !== exp_insn(0, 0)) begin
            n_fails++;
            $display("FAIL in_order_c3: valid=%0b order=%0d check=%0b insn=%h (want 1 0 1 %h)",
                     out_valid, out_order, check, out_insn, exp_insn(0, 0));
        end
        set_ch(0, 64'd2, 8'd0); tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd1 || check !== 1'b0 || out_pc_rdata !== XLEN'(4)) begin
            n_fails++;
            $display("FAIL in_order_c4: valid=%0b order=%0d check=%0b pc=%h (want 1 1 0 4)",
                     out_valid, out_order, check, out_pc_rdata);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd2 || check !== 1'b0 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL in_order_c5: valid=%0b order=%0d check=%0b err=%0b (want 1 2 0 0)",
                     out_valid, out_order, check, err);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || out_order !== 64'd2 || check !== 1'b0) begin
            n_fails++;
            $display("FAIL in_order_hold: valid=%0b order=%0d check=%0b (want 0 2 0)",
                     out_valid, out_order, check);
        end
    endtask

    task automatic test_reversed();
        do_reset();
        set_ch(0, 64'd1, 8'd0);
        set_ch(1, 64'd0, 8'd0);
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd2) begin
            n_fails++; $display("FAIL reversed_c2: valid=%0b pending=%0d (want 0 2)", out_valid, pending);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd0 || pending !== 4'd1) begin
            n_fails++;
            $display("FAIL reversed_c3: valid=%0b order=%0d pending=%0d (want 1 0 1)", out_valid, out_order, pending);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd1 || pending !== 4'd0 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL reversed_c4: valid=%0b order=%0d pending=%0d err=%0b (want 1 1 0 0)",
                     out_valid, out_order, pending, err);
        end
    endtask

    task automatic test_gap_fill();
        do_reset();
        set_ch(0, 64'd2, 8'd0);
        set_ch(1, 64'd3, 8'd0);
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd2) begin
            n_fails++; $display("FAIL gap_c3: valid=%0b pending=%0d (want 0 2)", out_valid, pending);
        end
        set_ch(0, 64'd0, 8'd0); tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd3) begin
            n_fails++; $display("FAIL gap_c5: valid=%0b pending=%0d (want 0 3)", out_valid, pending);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd0 || pending !== 4'd2) begin
            n_fails++;
            $display("FAIL gap_c6: valid=%0b order=%0d pending=%0d (want 1 0 2)", out_valid, out_order, pending);
        end
        set_ch(0, 64'd1, 8'd0); tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd3) begin
            n_fails++; $display("FAIL gap_c7: valid=%0b pending=%0d (want 0 3)", out_valid, pending);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_order !== 64'(i) || pending !== 4'(3 - i)) begin
                n_fails++;
                $display("FAIL gap_emit%0d: valid=%0b order=%0d pending=%0d (want 1 %0d %0d)",
                         i, out_valid, out_order, pending, i, 3 - i);
            end
        end
    endtask

    task automatic test_duplicate();
        int n5;
        int nall;
        n5 = 0;
        nall = 0;
        do_reset();
        set_ch(0, 64'd5, 8'd0);
        set_ch(1, 64'd5, 8'd1);
        tick();
        n_tests++;
        if (err !== 1'b1 || pending !== 4'd1) begin
            n_fails++; $display("FAIL dup_err: err=%0b pending=%0d (want 1 1)", err, pending);
        end
        for (int i = 0; i < 14; i++) begin
            if (i < 5) set_ch(0, 64'(i), 8'd0);
            tick();
            if (out_valid === 1'b1) nall++;
            if (out_valid === 1'b1 && out_order === 64'd5) begin
                n5++;
                n_tests++;
                if (out_insn !== exp_insn(5, 0)) begin
                    n_fails++;
                    $display("FAIL dup_payload: insn=%h (want %h)", out_insn, exp_insn(5, 0));
                end
            end
        end
        n_tests++;
        if (n5 != 1 || nall != 6 || err !== 1'b1) begin
            n_fails++;
            $display("FAIL dup_count: order5=%0d total=%0d err=%0b (want 1 6 1)", n5, nall, err);
        end
    endtask

    task automatic test_window();
        do_reset();
        set_ch(0, 64'd8, 8'd0); tick();
        n_tests++;
        if (err !== 1'b1 || pending !== 4'd0) begin
            n_fails++; $display("FAIL win_high: err=%0b pending=%0d (want 1 0)", err, pending);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 64'(i), 8'd0);
            tick();
        end
        tick();
        n_tests++;
        if (err !== 1'b0 || out_valid !== 1'b1 || out_order !== 64'd3) begin
            n_fails++;
            $display("FAIL win_setup: err=%0b valid=%0b order=%0d (want 0 1 3)", err, out_valid, out_order);
        end
        set_ch(0, 64'd3, 8'd0); tick();
        n_tests++;
        if (err !== 1'b1 || pending !== 4'd0) begin
            n_fails++; $display("FAIL win_low: err=%0b pending=%0d (want 1 0)", err, pending);
        end
        set_ch(0, 64'd11, 8'd0);
        set_ch(1, 64'd12, 8'd0);
        tick();
        n_tests++;
        if (pending !== 4'd1) begin
            n_fails++; $display("FAIL win_edge: pending=%0d (want 1)", pending);
        end
        // Refill of the slot being emitted is rejected, then accepted a cycle later.
        do_reset();
        set_ch(0, 64'd0, 8'd0); tick();
        set_ch(0, 64'd8, 8'd0); tick();
        n_tests++;
        if (err !== 1'b1 || out_valid !== 1'b1 || out_order !== 64'd0 || pending !== 4'd0) begin
            n_fails++;
            $display("FAIL win_refill_same: err=%0b valid=%0b order=%0d pending=%0d (want 1 1 0 0)",
                     err, out_valid, out_order, pending);
        end
        set_ch(0, 64'd8, 8'd0); tick();
        n_tests++;
        if (pending !== 4'd1) begin
            n_fails++; $display("FAIL win_refill_next: pending=%0d (want 1)", pending);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_ch(0, 64'd0, 8'd0);
        set_ch(1, 64'd3, 8'd0);
        tick();
        set_ch(0, 64'd4, 8'd0);
        set_ch(1, 64'd5, 8'd0);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_insn !== exp_insn(0, 0) || pending !== 4'd3 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_pre: valid=%0b insn=%h pending=%0d err=%0b (want 1 %h 3 0)",
                     out_valid, out_insn, pending, err, exp_insn(0, 0));
        end
        set_ch(1, 64'd20, 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd0 || err !== 1'b0 || out_insn !== '0 || check !== 1'b0) begin
            n_fails++;
            $display("FAIL midrst_post: valid=%0b pending=%0d err=%0b insn=%h check=%0b (want 0 0 0 0 0)",
                     out_valid, pending, err, out_insn, check);
        end
        set_ch(0, 64'd0, 8'd2); tick();
        n_tests++;
        if (out_valid !== 1'b0 || pending !== 4'd1) begin
            n_fails++; $display("FAIL midrst_c1: valid=%0b pending=%0d (want 0 1)", out_valid, pending);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_order !== 64'd0 || check !== 1'b1 ||
            out_insn !== exp_insn(0, 2) || pending !== 4'd0) begin
            n_fails++;
            $display("FAIL midrst_emit: valid=%0b order=%0d check=%0b insn=%h pending=%0d (want 1 0 1 %h 0)",
                     out_valid, out_order, check, out_insn, pending, exp_insn(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_reversed();
        test_gap_fill();
        test_duplicate();
        test_window();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
